// File: rtl/pwm_sample_fifo.sv
// Sample queue between the CPU-side producer and the PWM frame renderer.
// Occupancy is tracked by a level counter; pointers wrap naturally.
module pwm_sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == {LW{1'b0}});
    assign level_o   = level_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Pointer and level next-state; a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end
endmodule

// File: rtl/pwm_dac.sv
// PWM audio sink: buffers duty samples and renders one per 2^WIDTH-cycle frame
// on a registered single-bit output, flagging frames that start with no sample.
module pwm_dac #(
    parameter int WIDTH      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              sample_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pwm_out,
    output logic                          underrun,
    input  logic                          underrun_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             underrun_q, underrun_d;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [WIDTH-1:0] fifo_dout_s;
    logic             push_s;
    logic             pop_s;
    logic             boundary_s;

    // Ready depends only on occupancy and reset, never on this cycle's valid or pop.
    assign sample_ready = !fifo_full_s && !rst;
    assign push_s       = sample_valid && sample_ready;
    assign boundary_s   = enable && (cnt_q == CNT_MAX);
    assign pop_s        = boundary_s && !fifo_empty_s;

    pwm_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (sample_data),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level)
    );

    // Frame counter, duty reload at the boundary, compare and sticky underrun (set beats clear).
    always_comb begin
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        underrun_d = underrun_q;
        pwm_d      = enable && (cnt_q < duty_q);
        if (enable) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {WIDTH{1'b0}};
        end
        if (pop_s) begin
            duty_d = fifo_dout_s;
        end else begin
            duty_d = duty_q;
        end
        if (boundary_s && fifo_empty_s) begin
            underrun_d = 1'b1;
        end else if (underrun_clear) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // State registers; reset discards the frame position and the current duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= {WIDTH{1'b0}};
            duty_q     <= {WIDTH{1'b0}};
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
        end
    end

    assign pwm_out  = pwm_q;
    assign underrun = underrun_q;
endmodule
